pixel_reorder_buffer: RTL and testbench
=======================================

Name: pixel_reorder_buffer

Overview:
- Collects coloured pixel results from NUM_ENGINES parallel fractal engines, which complete out of order.
- Releases them strictly in raster order (x fastest, then y) on a valid/ready stream to the frame combinator/VGA writer.
- Tracks the expected next coordinate internally and wraps automatically at frame end.
- Absorbs out-of-order completion in a DEPTH-entry window, back-pressures engines that run too far ahead, and drops stale or duplicate results.

Parameters:
- NUM_ENGINES, 4, number of engine input channels.
- DEPTH, 16, reorder window size in pixels; power of two, at least 2.
- COLOUR_W, 24, RGB colour width.
- COORD_W, 32, x/y coordinate width.
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of window and expected coordinate.
- in_valid  in  NUM_ENGINES  per-engine result valid.
- in_ready  out  NUM_ENGINES  per-engine accept.
- in_x  in  NUM_ENGINES*COORD_W  packed x per engine.
- in_y  in  NUM_ENGINES*COORD_W  packed y per engine.
- in_colour  in  NUM_ENGINES*COLOUR_W  packed colour per engine.
- out_valid  out  1  head pixel available.
- out_ready  in  1  downstream accept.
- out_x, out_y  out  COORD_W  coordinate of the head pixel.
- out_colour  out  COLOUR_W  colour of the head pixel.
- out_sof  out  1  head pixel is (0,0).
- out_eol  out  1  head pixel x = IMG_W-1.
- full_queue  out  1  occupancy == DEPTH.
- occupancy  out  clog2(DEPTH)+1  number of filled slots.
- drop_pulse  out  1  one-cycle pulse when any input is dropped.

Behaviour:
- Reset (asynchronous, effective while high):
  - All slots empty, head = 0, expected (x,y) = (0,0).
  - out_valid = 0, full_queue = 0, occupancy = 0, drop_pulse = 0.
  - in_ready is combinational and follows the rules below from this cleared state.
- flush: same clear as reset, but synchronous at the clock edge. flush wins over any simultaneous push or pop.
- Linear index and offset:
  - idx = y*IMG_W + x; FRAME = IMG_W*IMG_H.
  - off = (idx - exp_idx) mod FRAME, computed with one conditional add of FRAME.
- Per-channel classification (combinational, from current state only):
  - x >= IMG_W or y >= IMG_H: invalid → in_ready = 1, dropped.
  - off < DEPTH, slot empty: store → in_ready = 1.
  - off < DEPTH, slot occupied: duplicate → in_ready = 1, dropped.
  - off >= FRAME/2: stale → in_ready = 1, dropped.
  - Otherwise: ahead of window → in_ready = 0 (stall).
- Storage:
  - Target slot = (head + off) mod DEPTH.
  - Slot valid bit, colour, x and y are written at the edge where in_valid & in_ready.
- Simultaneous channels:
  - Distinct offsets are all stored in the same cycle.
  - Equal offsets: the lowest channel index wins; the others are treated as duplicates.
- drop_pulse: asserted the cycle after any accepted-but-dropped input.
- Output:
  - out_valid = valid bit of slot[head], registered state. Minimum latency from accept at offset 0 to out_valid is 1 cycle.
  - Output fields are driven from slot[head]; they are don't-care when out_valid = 0.
- Pop (out_valid & out_ready):
  - Clear slot[head], head += 1 mod DEPTH.
  - Expected x += 1; at IMG_W-1, x wraps to 0 and y += 1; at (IMG_W-1, IMG_H-1), wraps to (0,0).
- Push and pop in the same cycle:
  - Classification uses pre-pop state.
  - The slot vacated by the pop is not writable until the next cycle.
  - occupancy += pushes - pop.
- Stall: with out_ready held low, the window fills, full_queue = 1, and only stale, duplicate or invalid inputs see in_ready = 1.
- Wrap-around: head pointer modulo DEPTH; frame index modulo FRAME.

Decomposition:
- Package pixel_pkg:
  - pixel_t struct {x, y, colour}.
  - FRAME and IDX_W = clog2(FRAME) localparams.
  - Classification enum {STORE, DUP, STALE, INVALID, STALL}.
- Sub-module pixel_slot_locator, instantiated once per channel:
  - Computes idx, off and class from coordinate, exp_idx and the slot-valid vector.
  - Purely combinational.
- Top level holds the slot array, head, expected-coordinate counters, arbitration and output logic.

Test Plan:
- In-order single engine: push (0,0),(1,0),(2,0) with out_ready = 1 → out in order, each 1 cycle after accept; out_sof on (0,0).
- Reverse order: engines 0-3 push (3,0),(2,0),(1,0),(0,0) in the same cycle → all accepted; out emits x = 0,1,2,3 on consecutive cycles; occupancy peaks at 4.
- Window stall: out_ready = 0, push (16,0) → in_ready = 0. Push x = 0..15 → full_queue = 1. Release out_ready → (16,0) accepted after the first pop.
- Duplicate and stale: engines 1 and 2 push (5,0) together → engine 1 stored, drop_pulse = 1. After (5,0) pops, re-push (5,0) → stale, drop_pulse = 1, no output.
- Frame wrap: stream all 640x480 pixels → out_eol at x = 639; after (639,479), expected returns to (0,0); the next (0,0) is emitted with out_sof.
- Reset mid-operation: assert reset asynchronously with 5 slots filled → out_valid, occupancy and full_queue drop to 0 immediately. After release, (0,0) is expected.

Source files
------------

// File: rtl/pixel_reorder_buffer_pkg.sv
// Shared types for the pixel reorder buffer: pixel record, frame geometry defaults
// and the per-channel classification of an incoming engine result.
package pixel_pkg;

  localparam int DEF_IMG_W    = 640;
  localparam int DEF_IMG_H    = 480;
  localparam int DEF_COORD_W  = 32;
  localparam int DEF_COLOUR_W = 24;
  localparam int FRAME        = DEF_IMG_W * DEF_IMG_H;
  localparam int IDX_W        = $clog2(FRAME);

  typedef struct packed {
    logic [DEF_COORD_W-1:0]  x;
    logic [DEF_COORD_W-1:0]  y;
    logic [DEF_COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [2:0] {
    STORE,
    DUP,
    STALE,
    INVALID,
    STALL
  } slot_class_t;

endpackage

// File: rtl/pixel_reorder_buffer_if.sv
// Engine-side and display-side handshake bundle of the pixel reorder buffer.
interface pixel_reorder_buffer_if #(
  parameter int NUM_ENGINES = 4,
  parameter int COORD_W     = 32,
  parameter int COLOUR_W    = 24,
  parameter int DEPTH       = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [NUM_ENGINES-1:0]          in_valid;
  logic [NUM_ENGINES-1:0]          in_ready;
  logic [NUM_ENGINES*COORD_W-1:0]  in_x;
  logic [NUM_ENGINES*COORD_W-1:0]  in_y;
  logic [NUM_ENGINES*COLOUR_W-1:0] in_colour;
  logic                            out_valid;
  logic                            out_ready;
  logic [COORD_W-1:0]              out_x;
  logic [COORD_W-1:0]              out_y;
  logic [COLOUR_W-1:0]             out_colour;
  logic                            out_sof;
  logic                            out_eol;
  logic                            full_queue;
  logic [OCC_W-1:0]                occupancy;
  logic                            drop_pulse;

  modport master (
    output in_valid, in_x, in_y, in_colour, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_colour, out_sof, out_eol,
           full_queue, occupancy, drop_pulse
  );

  modport slave (
    input  in_valid, in_x, in_y, in_colour, out_ready,
    output in_ready, out_valid, out_x, out_y, out_colour, out_sof, out_eol,
           full_queue, occupancy, drop_pulse
  );

endinterface

// File: rtl/pixel_reorder_buffer_locator.sv
// Maps one engine result onto the reorder window: raster offset from the expected
// pixel, target slot and classification. Purely combinational.
module pixel_slot_locator import pixel_pkg::*; #(
  parameter int DEPTH   = 16,
  parameter int COORD_W = 32,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int FRM     = IMG_W * IMG_H,
  parameter int IW      = $clog2(FRM),
  parameter int PW      = $clog2(DEPTH)
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [IW-1:0]      exp_idx,
  input  logic [PW-1:0]      head,
  input  logic [DEPTH-1:0]   slot_vld,
  output logic [PW-1:0]      slot,
  output slot_class_t        cls
);

  logic [IW-1:0] idx;
  logic [IW-1:0] off;
  logic [IW:0]   diff;
  logic          in_range;

  always_comb begin
    in_range = (x < COORD_W'(IMG_W)) && (y < COORD_W'(IMG_H));
    // Only meaningful when in range, where the true index fits in IW bits.
    idx  = y[IW-1:0] * IW'(IMG_W) + x[IW-1:0];
    diff = {1'b0, idx} - {1'b0, exp_idx};
    if (diff[IW]) diff = diff + (IW+1)'(FRM);
    off  = diff[IW-1:0];
    slot = head + PW'(off);

    if (!in_range)                 cls = INVALID;
    else if (off < IW'(DEPTH))     cls = slot_vld[slot] ? DUP : STORE;
    else if (off >= IW'(FRM / 2))  cls = STALE;
    else                           cls = STALL;
  end

endmodule

// File: rtl/pixel_reorder_buffer.sv
// Collects out-of-order engine pixels into a DEPTH-slot window and releases them in
// raster order; engines running beyond the window are stalled, stale/dup/invalid dropped.
module pixel_reorder_buffer import pixel_pkg::*; #(
  parameter int NUM_ENGINES = 4,
  parameter int DEPTH       = 16,
  parameter int COLOUR_W    = DEF_COLOUR_W,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   flush,
  pixel_reorder_buffer_if.slave bus
);

  localparam int FRM = IMG_W * IMG_H;
  localparam int IW  = $clog2(FRM);
  localparam int PW  = $clog2(DEPTH);
  localparam int OW  = PW + 1;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COLOUR_W-1:0] colour;
  } slot_t;

  slot_t                  slot_dat [DEPTH];
  logic [DEPTH-1:0]       slot_vld;
  logic [PW-1:0]          head;
  logic [IW-1:0]          exp_idx;
  logic                   drop_q;

  logic [PW-1:0]          tgt [NUM_ENGINES];
  slot_class_t            cls [NUM_ENGINES];
  logic [NUM_ENGINES-1:0] ready;
  logic [NUM_ENGINES-1:0] wr;
  logic [NUM_ENGINES-1:0] drop;
  logic [OW-1:0]          occ;
  logic                   pop;
  slot_t                  head_dat;

  for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_loc
    pixel_slot_locator #(
      .DEPTH(DEPTH), .COORD_W(COORD_W), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) u_loc (
      .x        (bus.in_x[i*COORD_W +: COORD_W]),
      .y        (bus.in_y[i*COORD_W +: COORD_W]),
      .exp_idx  (exp_idx),
      .head     (head),
      .slot_vld (slot_vld),
      .slot     (tgt[i]),
      .cls      (cls[i])
    );
  end

  // Lowest-numbered channel wins a contested slot; the losers count as duplicates.
  always_comb begin
    ready = '0;
    wr    = '0;
    drop  = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      ready[i] = (cls[i] != STALL);
      if (bus.in_valid[i] && ready[i]) begin
        wr[i] = (cls[i] == STORE);
        for (int j = 0; j < i; j++) begin
          if (bus.in_valid[j] && cls[j] == STORE && tgt[j] == tgt[i]) wr[i] = 1'b0;
        end
        drop[i] = !wr[i];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int d = 0; d < DEPTH; d++) occ = occ + OW'(slot_vld[d]);
  end

  assign pop = slot_vld[head] & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld <= '0;
      head     <= '0;
      exp_idx  <= '0;
      drop_q   <= 1'b0;
    end else if (flush) begin
      slot_vld <= '0;
      head     <= '0;
      exp_idx  <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= |drop;
      // A popped slot is never a write target this cycle: it was occupied pre-pop.
      if (pop) begin
        slot_vld[head] <= 1'b0;
        head           <= head + 1'b1;
        exp_idx        <= (exp_idx == IW'(FRM - 1)) ? '0 : exp_idx + 1'b1;
      end
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (wr[i]) slot_vld[tgt[i]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (wr[i]) begin
        slot_dat[tgt[i]] <= {bus.in_x[i*COORD_W +: COORD_W],
                             bus.in_y[i*COORD_W +: COORD_W],
                             bus.in_colour[i*COLOUR_W +: COLOUR_W]};
      end
    end
  end

  assign head_dat       = slot_dat[head];
  assign bus.in_ready   = ready;
  assign bus.out_valid  = slot_vld[head];
  assign bus.out_x      = head_dat.x;
  assign bus.out_y      = head_dat.y;
  assign bus.out_colour = head_dat.colour;
  assign bus.out_sof    = slot_vld[head] && head_dat.x == '0 && head_dat.y == '0;
  assign bus.out_eol    = slot_vld[head] && head_dat.x == COORD_W'(IMG_W - 1);
  assign bus.occupancy  = occ;
  assign bus.full_queue = (occ == OW'(DEPTH));
  assign bus.drop_pulse = drop_q;

endmodule

// File: tb/tb_pixel_reorder_buffer.sv
// Scoreboard bench for pixel_reorder_buffer; a 64x8 frame keeps the full-frame wrap short.
module tb_pixel_reorder_buffer;
  import pixel_pkg::*;

  localparam int NE = 4;
  localparam int D  = 16;
  localparam int CW = 32;
  localparam int KW = 24;
  localparam int W  = 64;
  localparam int H  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  pixel_reorder_buffer_if #(.NUM_ENGINES(NE), .COORD_W(CW), .COLOUR_W(KW), .DEPTH(D)) bus ();

  pixel_reorder_buffer #(
    .NUM_ENGINES(NE), .DEPTH(D), .COLOUR_W(KW), .COORD_W(CW), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  pixel_t sb[$];
  pixel_t mon_e;
  int     wx, wy;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] colour_of(int x, int y);
    return KW'((x * 997) ^ (y << 12) ^ 24'h5A5A5A);
  endfunction

  task automatic push_exp(int x, int y);
    pixel_t p;
    p.x = CW'(x);
    p.y = CW'(y);
    p.colour = colour_of(x, y);
    sb.push_back(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int e, int x, int y);
    bus.in_valid[e]          = 1'b1;
    bus.in_x[e*CW +: CW]     = CW'(x);
    bus.in_y[e*CW +: CW]     = CW'(y);
    bus.in_colour[e*KW +: KW] = colour_of(x, y);
  endtask

  task automatic send1(int e, int x, int y);
    int n;
    n = 0;
    set_in(e, x, y);
    #1;
    while (!bus.in_ready[e] && n < 40) begin
      tick();
      n++;
    end
    chk("send_ready", n < 40, 1);
    tick();
    bus.in_valid[e] = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Every popped pixel must match the next raster-order expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out_x", bus.out_x, mon_e.x);
        chk("out_y", bus.out_y, mon_e.y);
        chk("out_colour", bus.out_colour, mon_e.colour);
        chk("out_sof", bus.out_sof, (mon_e.x == 0 && mon_e.y == 0));
        chk("out_eol", bus.out_eol, (mon_e.x == W - 1));
      end
    end
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_colour = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_occupancy", bus.occupancy, 0);
    chk("rst_full", bus.full_queue, 0);
    chk("rst_drop", bus.drop_pulse, 0);
    chk("rst_in_ready", bus.in_ready, 4'hf);
    #10 reset = 1'b0;
    tick();

    // In-order single engine
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_exp(k, 0);
      send1(0, k, 0);
      chk("lat_valid", bus.out_valid, 1);
      chk("lat_x", bus.out_x, k);
    end
    tick();
    chk("inorder_idle", bus.out_valid, 0);

    // Reverse order in one cycle
    do_flush();
    for (int k = 0; k < 4; k++) push_exp(k, 0);
    set_in(0, 3, 0);
    set_in(1, 2, 0);
    set_in(2, 1, 0);
    set_in(3, 0, 0);
    #1;
    chk("rev_ready", bus.in_ready, 4'hf);
    tick();
    bus.in_valid = '0;
    chk("rev_occ_peak", bus.occupancy, 4);
    tick();
    chk("rev_next_x", bus.out_x, 1);
    chk("rev_occ3", bus.occupancy, 3);
    repeat (3) tick();
    chk("rev_drained", bus.occupancy, 0);

    // Window stall
    do_flush();
    bus.out_ready = 1'b0;
    set_in(0, 16, 0);
    #1;
    chk("stall_ready", bus.in_ready[0], 0);
    for (int k = 0; k < 16; k++) begin
      push_exp(k, 0);
      send1(1, k, 0);
    end
    push_exp(16, 0);
    chk("full_queue", bus.full_queue, 1);
    chk("occ_full", bus.occupancy, 16);
    chk("stall_hold", bus.in_ready[0], 0);
    set_in(2, 3, 0);
    #1;
    chk("full_dup_ready", bus.in_ready[2], 1);
    bus.in_valid[2] = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("stall_release", bus.in_ready[0], 1);
    tick();
    bus.in_valid[0] = 1'b0;
    repeat (20) tick();
    chk("stall_drained", bus.occupancy, 0);

    // Duplicate, stale and invalid
    do_flush();
    set_in(1, 5, 0);
    set_in(2, 5, 0);
    #1;
    chk("dup_ready", bus.in_ready[2:1], 2'b11);
    tick();
    bus.in_valid = '0;
    chk("dup_drop", bus.drop_pulse, 1);
    chk("dup_occ", bus.occupancy, 1);
    for (int k = 0; k < 6; k++) push_exp(k, 0);
    for (int k = 0; k < 5; k++) begin
      send1(0, k, 0);
      if (k == 0) chk("no_drop", bus.drop_pulse, 0);
    end
    repeat (3) tick();
    chk("dup_drained", bus.occupancy, 0);
    send1(0, 5, 0);
    chk("stale_drop", bus.drop_pulse, 1);
    chk("stale_occ", bus.occupancy, 0);
    tick();
    chk("stale_no_out", bus.out_valid, 0);
    send1(3, W, 0);
    chk("invalid_drop", bus.drop_pulse, 1);

    // Full frame wrap
    do_flush();
    for (int k = 0; k <= W * H; k++) begin
      wx = k % W;
      wy = (k / W) % H;
      push_exp(wx, wy);
      send1(0, wx, wy);
    end
    chk("wrap_sof", bus.out_sof, 1);
    repeat (4) tick();
    chk("wrap_drained", bus.occupancy, 0);

    // Asynchronous reset with slots filled
    do_flush();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send1(0, k, 0);
    chk("pre_rst_occ", bus.occupancy, 5);
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_occ", bus.occupancy, 0);
    chk("mid_rst_full", bus.full_queue, 0);
    #3 reset = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    push_exp(0, 0);
    send1(0, 0, 0);
    chk("post_rst_sof", bus.out_sof, 1);
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
